// File: rtl/div_pkg.sv
// Shared constants for the streaming divider stage.
package div_pkg;

  // Dividend width; divisor, quotient and remainder are half this width.
  localparam int N_DEF      = 16;
  // Width of the saturating error-result counter.
  localparam int CNT_W_DEF  = 8;
  // Number of result entries held between the divider and the consumer.
  localparam int FIFO_DEPTH = 2;

endpackage : div_pkg

// File: rtl/N_integer_divider_posr.sv
// Combinational signed divider with a non-negative remainder:
// x = q*y + r with 0 <= r < |y|. no_idiv flags a zero divisor or a
// quotient that does not fit the signed N/2-bit result range.
module N_integer_divider_posr #(
  parameter int N = 16
) (
  input  logic signed [N-1:0]   x,
  input  logic signed [N/2-1:0] y,
  output logic signed [N/2-1:0] q,
  output logic        [N/2-1:0] r,
  output logic                  no_idiv
);

  localparam int H = N / 2;
  localparam logic signed [N:0] ONE = 1;

  // One extra bit keeps -2^(N-1) / -1 representable before the range test.
  logic signed [N:0] xe;
  logic signed [N:0] ye;
  logic signed [N:0] q_t;
  logic signed [N:0] r_t;
  logic signed [N:0] q_adj;
  logic signed [N:0] r_adj;
  logic              q_fits;

  // Truncating divide, then shift the remainder into [0, |y|).
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    xe     = {x[N-1], x};
    ye     = (y == '0) ? ONE : {{(N + 1 - H){y[H-1]}}, y};
    q_t    = xe / ye;
    r_t    = xe % ye;
    q_adj  = q_t;
    r_adj  = r_t;
    if (r_t[N]) begin
      if (!y[H-1]) begin
        q_adj = q_t - ONE;
        r_adj = r_t + ye;
      end else begin
        q_adj = q_t + ONE;
        r_adj = r_t - ye;
      end
    end
    // Quotient fits when all bits above the result sign bit match it.
    q_fits  = (&q_adj[N:H-1]) || (~|q_adj[N:H-1]);
    no_idiv = (y == '0) || !q_fits;
    q       = q_adj[H-1:0];
    r       = r_adj[H-1:0];
  end

endmodule : N_integer_divider_posr

// File: rtl/div_stream_stage.sv
// Two-stage streaming divider: an operand register feeds a combinational
// divider whose results queue in a 2-entry FIFO toward the consumer.
module div_stream_stage
  import div_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       x,
  input  logic [N/2-1:0]     y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N/2-1:0]     q,
  output logic [N/2-1:0]     r,
  output logic               err,
  output logic [CNT_W-1:0]   err_count
);

  localparam int H = N / 2;

  // Stage 1 operand register.
  logic         op_v;
  logic [N-1:0] op_x;
  logic [H-1:0] op_y;

  // Divider results for the registered operands.
  logic [H-1:0] div_q;
  logic [H-1:0] div_r;
  logic         div_err;

  // Stage 2 result FIFO.
  logic [H-1:0] mem_q   [FIFO_DEPTH];
  logic [H-1:0] mem_r   [FIFO_DEPTH];
  logic         mem_err [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic push;
  logic pop;
  logic in_fire;

  N_integer_divider_posr #(.N(N)) u_div (
    .x       (op_x),
    .y       (op_y),
    .q       (div_q),
    .r       (div_r),
    .no_idiv (div_err)
  );

  // Handshakes; reset suppresses every transfer in the cycle it is applied.
  always_comb begin
    out_valid = !reset && (count != 2'd0);
    pop       = out_valid && out_ready;
    push      = !reset && op_v && ((count != 2'(FIFO_DEPTH)) || pop);
    in_ready  = !reset && (!op_v || push);
    in_fire   = in_valid && in_ready;
  end

  // Head entry is presented only while valid, zero otherwise.
  always_comb begin
    q   = out_valid ? mem_q[rd_ptr]   : '0;
    r   = out_valid ? mem_r[rd_ptr]   : '0;
    err = out_valid ? mem_err[rd_ptr] : 1'b0;
  end

  // Operand register: load on accept, release once its result is pushed.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) begin
      op_v <= 1'b0;
    end else if (in_fire) begin
      op_v <= 1'b1;
      op_x <= x;
      op_y <= y;
    end else if (push) begin
      op_v <= 1'b0;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; count alone decides which entries are valid.
    if (push) begin
      mem_q[wr_ptr]   <= div_q;
      mem_r[wr_ptr]   <= div_r;
      mem_err[wr_ptr] <= div_err;
    end
  end

  // FIFO pointers (1-bit, wrap 1->0) and occupancy 0..2.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of delivered error results.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (pop && mem_err[rd_ptr] && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule : div_stream_stage

// File: doc/div_stream_stage.md
DIV_STREAM_STAGE -- requirements
Module: div_stream_stage

Interface
REQ-001 Parameter N, default 16, dividend width; divisor, quotient and remainder widths SHALL be N/2.
REQ-002 Parameter CNT_W, default 8, width of the saturating error counter.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer presents an operand pair.
REQ-006 in_ready  output  1  stage can accept an operand pair this cycle.
REQ-007 x  input  N  signed two's-complement dividend.
REQ-008 y  input  N/2  signed two's-complement divisor.
REQ-009 out_valid  output  1  a result is available at the FIFO head.
REQ-010 out_ready  input  1  consumer takes the head result.
REQ-011 q  output  N/2  signed quotient of the head entry.
REQ-012 r  output  N/2  remainder of the head entry.
REQ-013 err  output  1  head entry is invalid (divisor zero, quotient overflow or range fail).
REQ-014 err_count  output  CNT_W  number of err results delivered, saturating.

Function
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-016 An output transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-017 Stage 1: a transfer SHALL load x and y into an operand register and set its valid bit (op_v).
REQ-018 Stage 2: the registered operands SHALL drive the combinational signed divider; its q, r and error flag SHALL be written as one entry into a 2-entry output FIFO at the edge where op_v=1 and the FIFO is not full after that edge's pop.
REQ-019 in_ready SHALL be high when op_v=0 or the stage-2 write happens in the same cycle (pass-through refill, no bubble).
REQ-020 Minimum latency SHALL be 2 cycles: a transfer at edge t SHALL give out_valid=1 after edge t+1.
REQ-021 With out_ready held high, throughput SHALL be one result per cycle.
REQ-022 FIFO full with no pop: op_v SHALL hold, operands SHALL stay stable, in_ready SHALL be 0.
REQ-023 Simultaneous push and pop on a full FIFO SHALL be allowed; occupancy SHALL stay 2.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL NOT bypass; the entry SHALL appear the next cycle.
REQ-025 FIFO pointers SHALL be 1 bit and wrap 1->0; occupancy SHALL be tracked as 0..2.
REQ-026 q, r and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 When out_valid=0, q, r and err SHALL be driven to 0.
REQ-028 err_count SHALL increment on each output transfer with err=1, and SHALL saturate at 2^CNT_W-1.
REQ-029 Results with err=1 SHALL still be delivered in order; their q and r are don't-care.

Reset
REQ-030 While reset is high at an edge: op_v=0, FIFO occupancy=0, pointers=0, err_count=0.
REQ-031 After reset: out_valid=0, q=r=0, err=0, in_ready=1.
REQ-032 A reset asserted mid-operation SHALL discard the pending operand and all FIFO entries, and no transfer SHALL be reported in that cycle.

Structure
REQ-033 N, CNT_W defaults and the FIFO depth constant (2) SHALL live in a shared package div_pkg.
REQ-034 One sub-module instance SHALL be used: the team's combinational signed divider N_integer_divider_posr, with x, y, q, r and no_idiv mapped to err.
REQ-035 The FIFO SHALL be inline storage, not a separate module.

Verification
REQ-036 Reset, then x=100, y=7, one-cycle in_valid, out_ready=1 -> out_valid after 2 edges, q=14, r=2, err=0, err_count=0.
REQ-037 x=50, y=0 -> err=1; after the pop, err_count=1.
REQ-038 x=1000, y=3 (quotient exceeds the N/2 range) -> err=1.
REQ-039 out_ready=0, 4 back-to-back inputs -> 2 entries stored plus 1 held operand; in_ready=0 from the 4th cycle; raise out_ready -> all 4 results delivered in order, none lost.
REQ-040 out_ready=1, 8 back-to-back inputs -> 8 results on consecutive cycles, in_ready held at 1.
REQ-041 Reset asserted while FIFO holds 2 entries -> next cycle out_valid=0, err_count=0, in_ready=1; 300 error results with CNT_W=8 -> err_count=255.
